// File: rtl/redun_chk_stage.sv
// Receive-side redundancy check: 4-phase in, one check register, 4-phase out; good msgs forwarded, bad dropped+counted.
// Latency rcv0_req@E0 -> snd0_req after E2; holds rcv0_ack low while in_buf is occupied (max 2 msgs buffered).
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif

module redun_chk_stage #(
  parameter int RSZ = `NS_REDUN_SIZE,
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE,
  parameter int CSZ = 8
) (
  input  logic           i_clk,
  input  logic           reset_n,
  input  logic [ASZ-1:0] rcv0_src,
  input  logic [ASZ-1:0] rcv0_dst,
  input  logic [DSZ-1:0] rcv0_dat,
  input  logic [RSZ-1:0] rcv0_red,
  input  logic           rcv0_req,
  output logic           rcv0_ack,
  output logic [ASZ-1:0] snd0_src,
  output logic [ASZ-1:0] snd0_dst,
  output logic [DSZ-1:0] snd0_dat,
  output logic [RSZ-1:0] snd0_red,
  output logic           snd0_req,
  input  logic           snd0_ack,
  output logic           err_pulse,
  output logic [CSZ-1:0] err_cnt
);
  localparam int MSZ = 2*ASZ + DSZ;
  localparam int SL  = MSZ / RSZ;

  typedef struct packed {
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
  } msg_t;

  typedef enum logic       {R_IDLE, R_ACK} rstate_t;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} sstate_t;

  rstate_t        r_state_q, r_state_d;
  sstate_t        s_state_q, s_state_d;
  logic           rcv0_ack_q, rcv0_ack_d;
  logic           in_full_q, in_full_d;
  msg_t           in_msg_q, in_msg_d;
  logic [RSZ-1:0] in_red_q, in_red_d;
  logic           chk_full_q, chk_full_d;
  msg_t           chk_msg_q, chk_msg_d;
  logic [RSZ-1:0] chk_red_q, chk_red_d;
  logic           chk_ok_q, chk_ok_d;
  msg_t           snd_msg_q, snd_msg_d;
  logic [RSZ-1:0] snd_red_q, snd_red_d;
  logic           snd_req_q, snd_req_d;
  logic           err_pulse_q, err_pulse_d;
  logic [CSZ-1:0] err_cnt_q, err_cnt_d;

  logic [MSZ-1:0] in_bits;
  logic [RSZ-1:0] red_calc;

  // Each redundancy bit is the NAND of one slice; the top slice absorbs the remainder bits.
  assign in_bits = in_msg_q;
  always_comb begin
    red_calc = '0;
    for (int i = 0; i < RSZ-1; i++) red_calc[i] = ~&in_bits[i*SL +: SL];
    red_calc[RSZ-1] = ~&in_bits[MSZ-1:(RSZ-1)*SL];
  end

  always_comb begin
    r_state_d   = r_state_q;
    s_state_d   = s_state_q;
    rcv0_ack_d  = rcv0_ack_q;
    in_full_d   = in_full_q;
    in_msg_d    = in_msg_q;
    in_red_d    = in_red_q;
    chk_full_d  = chk_full_q;
    chk_msg_d   = chk_msg_q;
    chk_red_d   = chk_red_q;
    chk_ok_d    = chk_ok_q;
    snd_msg_d   = snd_msg_q;
    snd_red_d   = snd_red_q;
    snd_req_d   = snd_req_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (in_full_q && !chk_full_q) begin
      chk_msg_d  = in_msg_q;
      chk_red_d  = red_calc;
      chk_ok_d   = (red_calc == in_red_q);
      chk_full_d = 1'b1;
      in_full_d  = 1'b0;
    end

    // Capture decision uses the registered in_full, so no same-cycle bypass into the check stage.
    case (r_state_q)
      R_IDLE: if (rcv0_req && !in_full_q) begin
        in_msg_d.src = rcv0_src;
        in_msg_d.dst = rcv0_dst;
        in_msg_d.dat = rcv0_dat;
        in_red_d     = rcv0_red;
        in_full_d    = 1'b1;
        rcv0_ack_d   = 1'b1;
        r_state_d    = R_ACK;
      end
      R_ACK: if (!rcv0_req) begin
        rcv0_ack_d = 1'b0;
        r_state_d  = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase

    case (s_state_q)
      S_IDLE: if (chk_full_q) begin
        if (chk_ok_q) begin
          snd_msg_d = chk_msg_q;
          snd_red_d = chk_red_q;
          snd_req_d = 1'b1;
          s_state_d = S_REQ;
        end else begin
          chk_full_d  = 1'b0;
          err_pulse_d = 1'b1;
          if (err_cnt_q != {CSZ{1'b1}}) err_cnt_d = err_cnt_q + CSZ'(1);
        end
      end
      S_REQ: if (snd0_ack) begin
        snd_req_d = 1'b0;
        s_state_d = S_REL;
      end
      S_REL: if (!snd0_ack) begin
        chk_full_d = 1'b0;
        s_state_d  = S_IDLE;
      end
      default: s_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state_q   <= R_IDLE;
      s_state_q   <= S_IDLE;
      rcv0_ack_q  <= 1'b0;
      in_full_q   <= 1'b0;
      in_msg_q    <= '0;
      in_red_q    <= '0;
      chk_full_q  <= 1'b0;
      chk_msg_q   <= '0;
      chk_red_q   <= '0;
      chk_ok_q    <= 1'b0;
      snd_msg_q   <= '0;
      snd_red_q   <= '0;
      snd_req_q   <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      r_state_q   <= r_state_d;
      s_state_q   <= s_state_d;
      rcv0_ack_q  <= rcv0_ack_d;
      in_full_q   <= in_full_d;
      in_msg_q    <= in_msg_d;
      in_red_q    <= in_red_d;
      chk_full_q  <= chk_full_d;
      chk_msg_q   <= chk_msg_d;
      chk_red_q   <= chk_red_d;
      chk_ok_q    <= chk_ok_d;
      snd_msg_q   <= snd_msg_d;
      snd_red_q   <= snd_red_d;
      snd_req_q   <= snd_req_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rcv0_ack  = rcv0_ack_q;
  assign snd0_src  = snd_msg_q.src;
  assign snd0_dst  = snd_msg_q.dst;
  assign snd0_dat  = snd_msg_q.dat;
  assign snd0_red  = snd_red_q;
  assign snd0_req  = snd_req_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_redun_chk_stage.sv
// Directed bench for redun_chk_stage with RSZ=4, ASZ=8, DSZ=8, CSZ=2 (6-bit slices).
module tb_redun_chk_stage;
  logic       clk, reset_n;
  logic [7:0] rcv0_src, rcv0_dst, rcv0_dat;
  logic [3:0] rcv0_red;
  logic       rcv0_req, rcv0_ack;
  logic [7:0] snd0_src, snd0_dst, snd0_dat;
  logic [3:0] snd0_red;
  logic       snd0_req, snd0_ack;
  logic       err_pulse;
  logic [1:0] err_cnt;

  redun_chk_stage #(.RSZ(4), .ASZ(8), .DSZ(8), .CSZ(2)) dut (
    .i_clk(clk), .reset_n(reset_n),
    .rcv0_src(rcv0_src), .rcv0_dst(rcv0_dst), .rcv0_dat(rcv0_dat), .rcv0_red(rcv0_red),
    .rcv0_req(rcv0_req), .rcv0_ack(rcv0_ack),
    .snd0_src(snd0_src), .snd0_dst(snd0_dst), .snd0_dat(snd0_dat), .snd0_red(snd0_red),
    .snd0_req(snd0_req), .snd0_ack(snd0_ack),
    .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  // Hand-computed {src,dst,dat,red}; red[i] = NAND of msg bits [6i+5:6i].
  localparam logic [27:0] M1 = 28'h052A09F; // no all-ones slice
  localparam logic [27:0] M2 = 28'h12343FE; // slice0 all ones
  localparam logic [27:0] M3 = 28'hFC00007; // slice3 all ones
  localparam logic [27:0] M4 = 28'h03FFC09; // slices1,2 all ones
  localparam logic [27:0] MF = 28'hFFFFFF0; // every slice all ones

  int nvec = 0, nmis = 0;
  int cyc = 0;
  int npulse = 0;
  bit sink_en = 0;
  int ack_dly = 0;
  logic [27:0] rxq[$];
  int done_q[$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;
  always @(negedge clk) if (err_pulse) npulse = npulse + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Downstream sink: acks each request after ack_dly cycles and logs what it saw.
  initial begin
    int n;
    snd0_ack = 0;
    forever begin
      @(negedge clk);
      if (sink_en && snd0_req && reset_n) begin
        repeat (ack_dly) @(negedge clk);
        rxq.push_back({snd0_src, snd0_dst, snd0_dat, snd0_red});
        snd0_ack = 1;
        n = 0;
        while (snd0_req && n < 50) begin
          @(negedge clk);
          n++;
        end
        if (snd0_req) chk("snd_rel_timeout", 32'(snd0_req), 32'd0);
        snd0_ack = 0;
        done_q.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [27:0] m, output int waitc, output int ack_cyc);
    int n;
    {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red} = m;
    rcv0_req = 1;
    waitc = 0;
    do begin
      @(negedge clk);
      waitc++;
    end while (!rcv0_ack && waitc < 100);
    ack_cyc = cyc;
    if (!rcv0_ack) chk("rcv_ack_timeout", 32'(rcv0_ack), 32'd1);
    rcv0_req = 0;
    n = 0;
    while (rcv0_ack && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (rcv0_ack) chk("rcv_rel_timeout", 32'(rcv0_ack), 32'd0);
  endtask

  task automatic wait_rx(input int n, input int maxc);
    int c = 0;
    while (rxq.size() < n && c < maxc) begin
      @(negedge clk);
      c++;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    rcv0_req = 0;
    sink_en  = 0;
    reset_n  = 0;
    repeat (2) @(negedge clk);
    rxq.delete();
    done_q.delete();
    npulse  = 0;
    reset_n = 1;
    @(negedge clk);
  endtask

  int w, ac, w1, w2, w3, ac3;
  int exp_cnt[5] = '{1, 2, 3, 3, 3};

  initial begin
    rcv0_req = 0;
    {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red} = '0;
    reset_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_rcv0_ack", 32'(rcv0_ack), 32'd0);
    chk("rst_snd0_req", 32'(snd0_req), 32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_snd_fields", 32'({snd0_src, snd0_dst, snd0_dat, snd0_red}), 32'd0);

    // 1: good message, exact latency
    do_reset();
    {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red} = M1;
    rcv0_req = 1;
    @(negedge clk);
    chk("t1_ack_after_e0", 32'(rcv0_ack), 32'd1);
    chk("t1_req_after_e0", 32'(snd0_req), 32'd0);
    rcv0_req = 0;
    @(negedge clk);
    chk("t1_req_after_e1", 32'(snd0_req), 32'd0);
    @(negedge clk);
    chk("t1_req_after_e2", 32'(snd0_req), 32'd1);
    chk("t1_fields", 32'({snd0_src, snd0_dst, snd0_dat, snd0_red}), 32'(M1));
    sink_en = 1;
    wait_rx(1, 50);
    chk("t1_rx_cnt", 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) chk("t1_rx0", 32'(rxq[0]), 32'(M1));
    chk("t1_err_cnt", 32'(err_cnt), 32'd0);

    // 2: same message, red bit0 flipped
    do_reset();
    sink_en = 1;
    send(M1 ^ 28'h1, w, ac);
    repeat (6) @(negedge clk);
    chk("t2_rx_cnt", 32'(rxq.size()), 32'd0);
    chk("t2_pulses", 32'(npulse), 32'd1);
    chk("t2_err_cnt", 32'(err_cnt), 32'd1);

    // 3: backpressure with 20-cycle ack delay
    do_reset();
    sink_en = 1;
    ack_dly = 20;
    send(M1, w1, ac);
    send(M2, w2, ac);
    send(M4, w3, ac3);
    chk("t3_m1_fast_ack", 32'(w1 <= 2), 32'd1);
    chk("t3_m2_fast_ack", 32'(w2 <= 2), 32'd1);
    chk("t3_m3_after_m1", 32'(done_q.size() > 0 && ac3 > done_q[0]), 32'd1);
    wait_rx(3, 300);
    chk("t3_rx_cnt", 32'(rxq.size()), 32'd3);
    if (rxq.size() == 3) begin
      chk("t3_rx0", 32'(rxq[0]), 32'(M1));
      chk("t3_rx1", 32'(rxq[1]), 32'(M2));
      chk("t3_rx2", 32'(rxq[2]), 32'(M4));
    end
    chk("t3_err_cnt", 32'(err_cnt), 32'd0);
    ack_dly = 0;

    // 4: saturating counter, CSZ=2
    do_reset();
    sink_en = 1;
    for (int i = 0; i < 5; i++) begin
      send(M1 ^ 28'h1, w, ac);
      repeat (4) @(negedge clk);
      chk($sformatf("t4_err_cnt_%0d", i), 32'(err_cnt), 32'(exp_cnt[i]));
    end
    chk("t4_pulses", 32'(npulse), 32'd5);
    chk("t4_rx_cnt", 32'(rxq.size()), 32'd0);

    // 5: async reset while snd0_req and rcv0_ack are high
    do_reset();
    sink_en = 1;
    send(M2 ^ 28'h1, w, ac);
    repeat (4) @(negedge clk);
    chk("t5_err_cnt_pre", 32'(err_cnt), 32'd1);
    sink_en = 0;
    send(M3, w, ac);
    for (int i = 0; i < 10 && !snd0_req; i++) @(negedge clk);
    chk("t5_snd_req_pre", 32'(snd0_req), 32'd1);
    {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red} = M4;
    rcv0_req = 1;
    @(negedge clk);
    chk("t5_rcv_ack_pre", 32'(rcv0_ack), 32'd1);
    #2 reset_n = 0;
    #1;
    chk("t5_snd_req_rst", 32'(snd0_req), 32'd0);
    chk("t5_rcv_ack_rst", 32'(rcv0_ack), 32'd0);
    chk("t5_err_cnt_rst", 32'(err_cnt), 32'd0);
    rcv0_req = 0;
    @(negedge clk);
    reset_n = 1;
    rxq.delete();
    @(negedge clk);
    sink_en = 1;
    send(MF, w, ac);
    wait_rx(1, 50);
    chk("t5_rx_cnt", 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) chk("t5_rx0", 32'(rxq[0]), 32'(MF));

    // 6: back-to-back good/bad/good with immediate ack
    do_reset();
    sink_en = 1;
    send(M4, w, ac);
    send(M1 ^ 28'h1, w, ac);
    send(M3, w, ac);
    wait_rx(2, 60);
    chk("t6_rx_cnt", 32'(rxq.size()), 32'd2);
    if (rxq.size() >= 2) begin
      chk("t6_rx0", 32'(rxq[0]), 32'(M4));
      chk("t6_rx1", 32'(rxq[1]), 32'(M3));
    end
    chk("t6_err_cnt", 32'(err_cnt), 32'd1);
    chk("t6_pulses", 32'(npulse), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
